// File: rtl/histogram_accum_dp.sv
`default_nettype none
// ============================================================================
//  Module   : histogram_accum_dp
//  Purpose  : Streaming histogram engine. Counts one bin index per clock into
//             a true dual-port RAM (2^BIN_AW x CNT_W) using a forwarded
//             read-modify-write pipeline, then streams every bin out on a
//             valid/ready port, optionally clearing bins as they are read.
//  Ports    : a_clk      - clock for all logic and both RAM ports
//             tb_a_rst   - asynchronous active-high reset
//             pix_valid  - pixel strobe (ignored while busy)
//             pix_bin    - bin index of the pixel
//             frame_end  - last-pixel pulse (only honoured in ACCUM)
//             hist_valid / hist_ready - readout handshake
//             hist_bin / hist_count / hist_last - readout beat
//             busy       - high in every state except ACCUM
//             ovf        - sticky per-frame saturate/wrap flag
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module histogram_accum_dp #(
  parameter int BIN_AW      = 9,
  parameter int CNT_W       = 32,
  parameter bit SATURATE    = 1'b1,
  parameter bit CLR_ON_READ = 1'b1
) (
  input  logic              a_clk,
  input  logic              tb_a_rst,
  input  logic              pix_valid,
  input  logic [BIN_AW-1:0] pix_bin,
  input  logic              frame_end,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [BIN_AW-1:0] hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              hist_last,
  output logic              busy,
  output logic              ovf
);

  localparam logic [BIN_AW-1:0] LAST_BIN = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_ACCUM   = 2'd1,
    S_DRAIN   = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Shared pointer: init clear address in INIT, fetch address in READOUT
  logic [BIN_AW-1:0] ptr_q, ptr_d;
  logic              fetch_done_q, fetch_done_d;
  logic              drain_q, drain_d;

  // RMW pipeline
  logic              s1_valid_q;
  logic [BIN_AW-1:0] s1_bin_q;
  logic              fwd_valid_q;
  logic [BIN_AW-1:0] fwd_bin_q;
  logic [CNT_W-1:0]  fwd_val_q;

  // Readout pipeline: RAM output stage and output register stage
  logic              rdv_q;
  logic [BIN_AW-1:0] rdb_q;
  logic              hist_valid_q;
  logic [BIN_AW-1:0] hist_bin_q;
  logic [CNT_W-1:0]  hist_count_q;
  logic              hist_last_q;
  logic              ovf_q;

  // RAM
  logic [CNT_W-1:0]  mem [0:(1<<BIN_AW)-1];
  logic [CNT_W-1:0]  ram_rd_q;
  logic              we_a;
  logic [BIN_AW-1:0] addr_a;
  logic [CNT_W-1:0]  din_a;
  logic              en_b;
  logic [BIN_AW-1:0] addr_b;

  logic              pix_acc;
  logic              out_adv;
  logic              r1_free;
  logic              fetch;
  logic              last_xfer;
  logic [CNT_W-1:0]  base;
  logic              sat_hit;
  logic [CNT_W-1:0]  inc_val;

  assign pix_acc   = (state_q == S_ACCUM) && pix_valid;
  assign out_adv   = !hist_valid_q || hist_ready;
  assign r1_free   = !rdv_q || out_adv;
  assign fetch     = (state_q == S_READOUT) && !fetch_done_q && r1_free;
  assign last_xfer = hist_valid_q && hist_ready && hist_last_q;

  // S1: the write issued last cycle landed at the same edge this read was
  // sampled, so the RAM data is stale for that one bin -- take the
  // forwarded value instead.
  always_comb begin
    base    = ram_rd_q;
    inc_val = '0;
    if (fwd_valid_q && (fwd_bin_q == s1_bin_q)) begin
      base = fwd_val_q;
    end
    sat_hit = (base == CNT_MAX);
    if (SATURATE && sat_hit) begin
      inc_val = base;
    end else begin
      inc_val = base + CNT_W'(1);
    end
  end

  // Port A: write-only. The sources never overlap in time (INIT has no
  // pixels, READOUT starts after the pipeline has drained).
  always_comb begin
    we_a   = 1'b0;
    addr_a = '0;
    din_a  = '0;
    if (state_q == S_INIT) begin
      we_a   = 1'b1;
      addr_a = ptr_q;
    end else if (s1_valid_q) begin
      we_a   = 1'b1;
      addr_a = s1_bin_q;
      din_a  = inc_val;
    end else if (fetch && CLR_ON_READ) begin
      we_a   = 1'b1;
      addr_a = ptr_q;
    end
  end

  // Port B: read-only, enabled only when a pixel or a fetch needs it so the
  // RAM output register holds its data during readout stalls.
  assign en_b   = pix_acc || fetch;
  assign addr_b = pix_acc ? pix_bin : ptr_q;

  always_ff @(posedge a_clk) begin
    if (we_a) begin
      mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge a_clk) begin
    if (en_b) begin
      ram_rd_q <= mem[addr_b];
    end
  end

  // FSM next-state
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    fetch_done_d = fetch_done_q;
    drain_d      = drain_q;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_BIN) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (frame_end) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d      = S_READOUT;
          ptr_d        = '0;
          fetch_done_d = 1'b0;
        end
      end
      S_READOUT: begin
        if (fetch) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LAST_BIN) begin
            fetch_done_d = 1'b1;
          end
        end
        if (last_xfer) begin
          state_d = S_ACCUM;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge a_clk or posedge tb_a_rst) begin
    if (tb_a_rst) begin
      state_q      <= S_INIT;
      ptr_q        <= '0;
      fetch_done_q <= 1'b0;
      drain_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fetch_done_q <= fetch_done_d;
      drain_q      <= drain_d;
    end
  end

  // Datapath registers
  always_ff @(posedge a_clk or posedge tb_a_rst) begin
    if (tb_a_rst) begin
      s1_valid_q   <= 1'b0;
      s1_bin_q     <= '0;
      fwd_valid_q  <= 1'b0;
      fwd_bin_q    <= '0;
      fwd_val_q    <= '0;
      rdv_q        <= 1'b0;
      rdb_q        <= '0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= '0;
      hist_count_q <= '0;
      hist_last_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      s1_valid_q  <= pix_acc;
      s1_bin_q    <= pix_bin;
      fwd_valid_q <= s1_valid_q;
      fwd_bin_q   <= s1_bin_q;
      fwd_val_q   <= inc_val;

      if (last_xfer) begin
        ovf_q <= 1'b0;
      end else if (s1_valid_q && sat_hit) begin
        ovf_q <= 1'b1;
      end

      if (r1_free) begin
        rdv_q <= fetch;
        rdb_q <= ptr_q;
      end

      if (out_adv) begin
        hist_valid_q <= rdv_q;
        if (rdv_q) begin
          hist_bin_q   <= rdb_q;
          hist_count_q <= ram_rd_q;
          hist_last_q  <= (rdb_q == LAST_BIN);
        end
      end
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_count = hist_count_q;
  assign hist_last  = hist_last_q;
  assign busy       = (state_q != S_ACCUM);
  assign ovf        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_histogram_accum_dp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_histogram_accum_dp
//  Purpose  : Self-checking bench for histogram_accum_dp. Two instances share
//             the stimulus: one saturating with clear-on-read, one wrapping
//             with accumulate-across-frames. A per-bin array model tracks the
//             expected counts and overflow flags of each.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_histogram_accum_dp;

  localparam int AW = 4;
  localparam int CW = 8;
  localparam int NB = 16;

  logic          a_clk = 1'b0;
  logic          tb_a_rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic [AW-1:0] pix_bin = '0;
  logic          frame_end = 1'b0;
  logic          hist_ready = 1'b0;

  logic          hv_s, hl_s, busy_s, ovf_s;
  logic [AW-1:0] hb_s;
  logic [CW-1:0] hc_s;
  logic          hv_w, hl_w, busy_w, ovf_w;
  logic [AW-1:0] hb_w;
  logic [CW-1:0] hc_w;

  always #5 a_clk = ~a_clk;

  histogram_accum_dp #(.BIN_AW(AW), .CNT_W(CW), .SATURATE(1'b1), .CLR_ON_READ(1'b1)) dut_s (
    .a_clk(a_clk), .tb_a_rst(tb_a_rst), .pix_valid(pix_valid), .pix_bin(pix_bin),
    .frame_end(frame_end), .hist_valid(hv_s), .hist_ready(hist_ready), .hist_bin(hb_s),
    .hist_count(hc_s), .hist_last(hl_s), .busy(busy_s), .ovf(ovf_s));

  histogram_accum_dp #(.BIN_AW(AW), .CNT_W(CW), .SATURATE(1'b0), .CLR_ON_READ(1'b0)) dut_w (
    .a_clk(a_clk), .tb_a_rst(tb_a_rst), .pix_valid(pix_valid), .pix_bin(pix_bin),
    .frame_end(frame_end), .hist_valid(hv_w), .hist_ready(hist_ready), .hist_bin(hb_w),
    .hist_count(hc_w), .hist_last(hl_w), .busy(busy_w), .ovf(ovf_w));

  int n_chk = 0;
  int n_err = 0;

  // Reference model
  int m_s[NB];
  int m_w[NB];
  bit ov_s, ov_w;
  int cap_s[NB];
  int cap_w[NB];

  typedef struct {
    int         bin_a;
    int         bin_b;
    int         npix;
    bit         fe_last;
    logic [3:0] rpat;
    int         exp_sa;
    int         exp_sb;
    int         exp_wa;
    int         exp_wb;
  } frame_vec_t;

  frame_vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_s[i] = 0;
      m_w[i] = 0;
    end
    ov_s = 1'b0;
    ov_w = 1'b0;
  endtask

  task automatic push_pix(input int b);
    if (m_s[b] == 255) ov_s = 1'b1;
    else m_s[b] = m_s[b] + 1;
    if (m_w[b] == 255) begin
      m_w[b] = 0;
      ov_w = 1'b1;
    end else begin
      m_w[b] = m_w[b] + 1;
    end
  endtask

  task automatic tick_in(input bit pv, input int b, input bit fe);
    @(negedge a_clk);
    pix_valid = pv;
    pix_bin   = AW'(b);
    frame_end = fe;
    if (pv) push_pix(b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_s || busy_w) && n < 200) begin
      @(negedge a_clk);
      n++;
    end
    if (busy_s || busy_w) chk("idle_timeout", 64'(busy_s), 64'(0));
  endtask

  // Counts the cycles busy stays high, sampling right after reset release.
  task automatic busy_count_after_release(input bit poke);
    int n;
    tb_a_rst  = 1'b0;
    pix_valid = poke;
    frame_end = poke;
    pix_bin   = 4'd3;
    n = 0;
    while (busy_s && n < 100) begin
      n++;
      @(negedge a_clk);
      pix_valid = 1'b0;
      frame_end = 1'b0;
    end
    chk("init_busy_cycles", 64'(n), 64'(NB));
    chk("init_busy_w", 64'(busy_w), 64'(0));
  endtask

  task automatic run_readout(input logic [3:0] rpat, input bit rnd, input int abort_at,
                             output bit aborted);
    int beat, cyc;
    bit pv, prdy, pl;
    logic [AW-1:0] pb;
    logic [CW-1:0] pcs, pcw;
    beat = 0; cyc = 0; pv = 0; prdy = 0; pl = 0; pb = '0; pcs = '0; pcw = '0;
    aborted = 1'b0;
    while (beat < NB && cyc < 400) begin
      @(negedge a_clk);
      pix_valid = 1'b0;
      frame_end = 1'b0;
      if (beat == abort_at && hv_s) begin
        tb_a_rst = 1'b1;
        #1;
        chk("rst_hist_valid", 64'({hv_s, hv_w}), 64'(0));
        chk("rst_hist_bin_count", 64'({hb_s, hc_s, hb_w, hc_w}), 64'(0));
        chk("rst_last_ovf", 64'({hl_s, ovf_s, hl_w, ovf_w}), 64'(0));
        chk("rst_busy", 64'({busy_s, busy_w}), 64'(2'b11));
        aborted = 1'b1;
        hist_ready = 1'b0;
        return;
      end
      hist_ready = rnd ? 1'($urandom_range(0, 1)) : rpat[cyc % 4];
      cyc++;
      chk("valid_match", 64'(hv_w), 64'(hv_s));
      if (pv && !prdy)
        chk("stall_hold", 64'({hv_s, hb_s, hc_s, hl_s, hv_w, hb_w, hc_w, hl_w}),
            64'({1'b1, pb, pcs, pl, 1'b1, pb, pcw, pl}));
      if (hv_s && hist_ready) begin
        chk("beat_bin", 64'({hb_s, hb_w}), 64'({AW'(beat), AW'(beat)}));
        chk("beat_count_s", 64'(hc_s), 64'(m_s[beat]));
        chk("beat_count_w", 64'(hc_w), 64'(m_w[beat]));
        chk("beat_last", 64'({hl_s, hl_w}), (beat == NB - 1) ? 64'(2'b11) : 64'(0));
        chk("beat_ovf", 64'({ovf_s, ovf_w}), 64'({ov_s, ov_w}));
        cap_s[beat] = int'(hc_s);
        cap_w[beat] = int'(hc_w);
        m_s[beat] = 0;
        beat++;
      end
      pv = hv_s; prdy = hist_ready; pb = hb_s; pcs = hc_s; pcw = hc_w; pl = hl_s;
    end
    if (beat < NB) chk("readout_timeout", 64'(beat), 64'(NB));
    @(negedge a_clk);
    hist_ready = 1'b0;
    chk("post_readout_busy", 64'({busy_s, busy_w}), 64'(0));
    chk("post_readout_ovf", 64'({ovf_s, ovf_w}), 64'(0));
    chk("post_readout_valid", 64'({hv_s, hv_w}), 64'(0));
    ov_s = 1'b0;
    ov_w = 1'b0;
  endtask

  initial begin
    bit ab;
    int n;

    tbl[0] = '{7, 2, 200, 1'b1, 4'b1111, 100, 100, 100, 100};
    tbl[1] = '{9, 9, 300, 1'b1, 4'b1111, 255, 255, 44, 44};
    tbl[2] = '{4, 11, 10, 1'b0, 4'b1001, 5, 5, 5, 5};
    tbl[3] = '{0, 15, 6, 1'b1, 4'b0110, 3, 3, 3, 3};

    model_clear();
    for (int i = 0; i < NB; i++) begin
      cap_s[i] = -1;
      cap_w[i] = -1;
    end

    // Reset values
    repeat (3) @(negedge a_clk);
    chk("reset_outputs", 64'({hv_s, hb_s, hc_s, hl_s, ovf_s}), 64'(0));
    chk("reset_busy", 64'({busy_s, busy_w}), 64'(2'b11));
    busy_count_after_release(1'b0);

    // Immediate empty frame
    tick_in(1'b0, 0, 1'b1);
    run_readout(4'b1111, 1'b0, -1, ab);

    // Back-to-back forwarding on one bin
    wait_idle();
    for (int i = 0; i < 4; i++) tick_in(1'b1, 3, 1'b0);
    tick_in(1'b1, 5, 1'b0);
    tick_in(1'b0, 0, 1'b1);
    run_readout(4'b1111, 1'b0, -1, ab);
    chk("fwd_bin3_s", 64'(cap_s[3]), 64'(4));
    chk("fwd_bin5_s", 64'(cap_s[5]), 64'(1));
    chk("fwd_bin3_w", 64'(cap_w[3]), 64'(4));

    // Second empty frame: cleared vs. retained counts, stalled readout
    wait_idle();
    tick_in(1'b0, 0, 1'b1);
    run_readout(4'b1001, 1'b0, -1, ab);
    chk("clr_on_read_bin3", 64'(cap_s[3]), 64'(0));
    chk("retain_bin3", 64'(cap_w[3]), 64'(4));
    chk("retain_bin5", 64'(cap_w[5]), 64'(1));

    // Table-driven frames
    for (int t = 0; t < 4; t++) begin
      wait_idle();
      for (int i = 0; i < tbl[t].npix; i++)
        tick_in(1'b1, (i % 2 == 0) ? tbl[t].bin_a : tbl[t].bin_b,
                tbl[t].fe_last && (i == tbl[t].npix - 1));
      if (!tbl[t].fe_last) tick_in(1'b0, 0, 1'b1);
      run_readout(tbl[t].rpat, 1'b0, -1, ab);
      chk($sformatf("tbl%0d_s_a", t), 64'(cap_s[tbl[t].bin_a]), 64'(tbl[t].exp_sa));
      chk($sformatf("tbl%0d_s_b", t), 64'(cap_s[tbl[t].bin_b]), 64'(tbl[t].exp_sb));
      chk($sformatf("tbl%0d_w_a", t), 64'(cap_w[tbl[t].bin_a]), 64'(tbl[t].exp_wa));
      chk($sformatf("tbl%0d_w_b", t), 64'(cap_w[tbl[t].bin_b]), 64'(tbl[t].exp_wb));
    end

    // Randomised frames with random gaps and random backpressure
    for (int f = 0; f < 5; f++) begin
      wait_idle();
      n = int'($urandom_range(20, 80));
      for (int i = 0; i < n; i++)
        tick_in(($urandom_range(0, 3) != 0), int'($urandom_range(0, NB - 1)), (i == n - 1));
      run_readout(4'b0000, 1'b1, -1, ab);
    end

    // Reset in the middle of readout
    wait_idle();
    for (int i = 1; i <= 8; i++) tick_in(1'b1, i, 1'b0);
    tick_in(1'b0, 0, 1'b1);
    run_readout(4'b1111, 1'b0, 6, ab);
    chk("abort_taken", 64'(ab), 64'(1));
    repeat (2) @(negedge a_clk);
    model_clear();
    // frame_end/pix_valid during INIT must be ignored
    busy_count_after_release(1'b1);
    repeat (5) @(negedge a_clk);
    chk("fe_in_init_ignored", 64'({busy_s, hv_s, busy_w, hv_w}), 64'(0));
    tick_in(1'b1, 6, 1'b0);
    tick_in(1'b1, 6, 1'b1);
    run_readout(4'b1111, 1'b0, -1, ab);
    chk("after_rst_bin6_s", 64'(cap_s[6]), 64'(2));
    chk("after_rst_bin6_w", 64'(cap_w[6]), 64'(2));
    chk("after_rst_bin3_w", 64'(cap_w[3]), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/histogram_accum_dp.md
Name: histogram_accum_dp

Overview:
- Streaming histogram engine built around an inferred true dual-port RAM of 2^BIN_AW x CNT_W. This is the parametrised successor of the fixed 512x32 histogram RAM.
- Accepts one bin index per clock and performs a forwarded read-modify-write increment, so back-to-back identical bins never lose counts.
- On frame end it drains the pipeline, then streams every bin count out over a valid/ready port, optionally clearing each bin as it is read.
- Sits between the pixel classifier and the equalisation/CDF stage of the image pipeline.

Parameters:
- BIN_AW, 9, bin address width; number of bins = 2^BIN_AW.
- CNT_W, 32, count width per bin.
- SATURATE, 1, 1 = counts clamp at 2^CNT_W-1; 0 = counts wrap modulo 2^CNT_W.
- CLR_ON_READ, 1, 1 = each bin is written to 0 when read out; 0 = counts accumulate across frames.

Ports:
- a_clk  in  1  single clock for all logic and both RAM ports.
- tb_a_rst  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel strobe; ignored while busy=1.
- pix_bin  in  BIN_AW  bin index of the pixel.
- frame_end  in  1  single-cycle pulse marking the last pixel; may coincide with pix_valid.
- hist_valid  out  1  readout data valid.
- hist_ready  in  1  downstream accept.
- hist_bin  out  BIN_AW  bin index of hist_count.
- hist_count  out  CNT_W  count of hist_bin.
- hist_last  out  1  high with the beat for bin 2^BIN_AW-1.
- busy  out  1  high in every state except ACCUM.
- ovf  out  1  sticky flag: a bin saturated or wrapped during the current frame.

Behaviour:
- Reset (async, tb_a_rst high):
  - FSM goes to INIT.
  - hist_valid, hist_last, ovf = 0; hist_bin, hist_count = 0; busy = 1.
  - Pipeline valid bits are cleared.
  - Reset in any state, including mid-READOUT, abandons the operation and restarts INIT.
- FSM states:
  - INIT: write 0 to bin i for i = 0..2^BIN_AW-1, one bin per cycle (2^BIN_AW cycles), then go to ACCUM.
  - ACCUM: busy = 0. A pixel is accepted when pix_valid=1. On frame_end go to DRAIN. A pixel in the same cycle as frame_end is counted.
  - DRAIN: 2 cycles, until the RMW pipeline is empty, then go to READOUT.
  - READOUT: stream bins 0..2^BIN_AW-1. After the beat with hist_last=1 is accepted, clear ovf and go to ACCUM.
- RMW pipeline:
  - S0 (accept cycle t): read address pix_bin on port B.
  - S1 (cycle t+1): read data returns. base = forwarded value if the S2 write in cycle t targeted the same bin, else RAM data.
  - S1 computes base+1. With SATURATE=1, base = 2^CNT_W-1 holds and sets ovf. With SATURATE=0 the count wraps to 0 and sets ovf.
  - S1 writes the result on port A in the same cycle, and registers bin/value as the forwarding source for the next cycle.
  - Only a distance-1 hazard exists; a write in cycle t-1 is visible to a read in cycle t.
  - Every cycle is fully pipelined: N pixels on N consecutive cycles to the same bin add exactly N.
- Readout:
  - Prefetch read; first hist_valid rises 2 cycles after entering READOUT.
  - hist_bin/hist_count/hist_last are held stable while hist_valid=1 and hist_ready=0.
  - A beat transfers on hist_valid & hist_ready. Sustained throughput is 1 bin/cycle when hist_ready is held at 1.
  - With CLR_ON_READ=1 the read bin is written to 0 on port A when its beat is fetched.
- frame_end outside ACCUM is ignored.
- pix_bin is used in full; there is no range check.

Test Plan (BIN_AW=4, CNT_W=8 unless stated):
- Reset, then wait → busy=1 for exactly 16 cycles, then 0. An immediate frame_end produces 16 beats of count 0, with hist_last on bin 15.
- Pixels 3,3,3,3 on consecutive cycles, then 5, then frame_end → bin3=4, bin5=1, all others 0. Checks back-to-back forwarding.
- Pattern 7,2,7,2 ×50 on consecutive cycles, frame_end together with the last pixel → bin7=100, bin2=100.
- 300 pixels to bin 9, SATURATE=1 → bin9=255, ovf=1 during readout and 0 after. Repeat with SATURATE=0 → bin9=44, ovf=1.
- Readout with hist_ready toggling 1,0,0,1 → outputs held during stalls, 16 beats in order, no beat dropped or duplicated. With CLR_ON_READ=1 a second empty frame reads all zeros; with CLR_ON_READ=0 it repeats the previous counts.
- Assert tb_a_rst on beat 6 of readout → outputs return to their reset values immediately. INIT re-runs, and the next frame's counts start from 0.
